// File: rtl/fifo_demux_rd.sv
// Read-side FIFO demux: pops words and steers them to four lanes by the word's two MSBs.
// Optional per-lane word counters and the words_out port are enabled with DEMUX_COUNT_EN.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_RESET  | first cycle out of reset, nothing issued
// ST_IDLE   | waiting for enable, no pops
// ST_ACTIVE | popping whenever the FIFO has data and the path is free
// ST_DRAIN  | no new pops; finishing the in-flight word and hold register
module fifo_demux_rd #(
  parameter int DATA_BITS = 10,
  parameter int CNT_BITS  = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [DATA_BITS-1:0] fifo_data_out,
  input  logic                 fifo_empty_out,
  output logic                 fifo_read,
  input  logic [3:0]           pause,
  output logic [DATA_BITS-1:0] data_out,
  output logic [3:0]           valid_out,
  output logic                 idle
`ifdef DEMUX_COUNT_EN
  ,
  output logic [4*CNT_BITS-1:0] words_out
`endif
);

  typedef enum logic [1:0] {ST_RESET, ST_IDLE, ST_ACTIVE, ST_DRAIN} state_t;

  state_t               state;
  logic                 rd_pend;
  logic                 hold_valid;
  logic [DATA_BITS-1:0] hold_data;

  logic                 cand_valid;
  logic [DATA_BITS-1:0] cand_data;
  logic [1:0]           dest;
  logic                 blocked;
  logic                 forward;

  // The hold register always has priority so word order is preserved.
  assign cand_valid = hold_valid | rd_pend;
  assign cand_data  = hold_valid ? hold_data : fifo_data_out;
  assign dest       = cand_data[DATA_BITS-1 -: 2];
  assign blocked    = cand_valid & pause[dest];
  assign forward    = cand_valid & ~pause[dest];

  assign fifo_read = (state == ST_ACTIVE) & ~fifo_empty_out & ~blocked;
  assign idle      = (state == ST_IDLE) & ~rd_pend & ~hold_valid;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_RESET;
      rd_pend    <= 1'b0;
      hold_valid <= 1'b0;
      hold_data  <= '0;
      data_out   <= '0;
      valid_out  <= '0;
    end else begin
      rd_pend <= fifo_read;

      if (forward) begin
        data_out   <= cand_data;
        valid_out  <= 4'b0001 << dest;
        hold_valid <= 1'b0;
      end else begin
        valid_out <= '0;
        if (blocked && !hold_valid) begin
          hold_valid <= 1'b1;
          hold_data  <= fifo_data_out;
        end
      end

      case (state)
        ST_RESET:  state <= ST_IDLE;
        ST_IDLE:   if (enable) state <= ST_ACTIVE;
        ST_ACTIVE: if (!enable) state <= ST_DRAIN;
        ST_DRAIN: begin
          if (enable)
            state <= ST_ACTIVE;
          else if (!rd_pend && !hold_valid)
            state <= ST_IDLE;
        end
        default:   state <= ST_RESET;
      endcase
    end
  end

`ifdef DEMUX_COUNT_EN
  logic [CNT_BITS-1:0] lane_cnt [4];

  // Counters wrap naturally and clear only on reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 4; i++) lane_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) lane_cnt[i] <= lane_cnt[i] + CNT_BITS'(valid_out[i]);
    end
  end

  for (genvar g = 0; g < 4; g++) begin : g_words
    assign words_out[g*CNT_BITS +: CNT_BITS] = lane_cnt[g];
  end
`endif

endmodule

// File: tb/tb_fifo_demux_rd.sv
// Directed bench for fifo_demux_rd with a behavioural FIFO model and hand-computed expectations.
// Counter checks are compiled in when DEMUX_COUNT_EN is defined.
module tb_fifo_demux_rd;
  localparam int DB = 10;
  localparam int CB = 8;

  logic          clk = 1'b1;
  logic          reset = 1'b0;
  logic          enable = 1'b0;
  logic [DB-1:0] fifo_data_out = '0;
  logic          fifo_empty_out = 1'b1;
  logic          fifo_read;
  logic [3:0]    pause = '0;
  logic [DB-1:0] data_out;
  logic [3:0]    valid_out;
  logic          idle;
`ifdef DEMUX_COUNT_EN
  logic [4*CB-1:0] words_out;
`endif

  fifo_demux_rd #(.DATA_BITS(DB), .CNT_BITS(CB)) dut (
    .clk           (clk),
    .reset         (reset),
    .enable        (enable),
    .fifo_data_out (fifo_data_out),
    .fifo_empty_out(fifo_empty_out),
    .fifo_read     (fifo_read),
    .pause         (pause),
    .data_out      (data_out),
    .valid_out     (valid_out),
    .idle          (idle)
`ifdef DEMUX_COUNT_EN
    ,
    .words_out     (words_out)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // FIFO model: read sampled before the edge, data presented just after it.
  logic [DB-1:0] q[$];
  bit rd_seen = 1'b0;
  bit rd_empty_err = 1'b0;
  int pops = 0;
  logic [DB+3:0] obs[$];

  always @(negedge clk) begin
    rd_seen = fifo_read;
    if (fifo_read && fifo_empty_out) rd_empty_err = 1'b1;
    if (fifo_read) pops++;
    if (valid_out != 4'b0) obs.push_back({valid_out, data_out});
  end

  always @(posedge clk) begin
    #1;
    if (rd_seen && q.size() > 0) fifo_data_out = q.pop_front();
    fifo_empty_out = (q.size() == 0);
  end

  task automatic push(input logic [DB-1:0] w);
    q.push_back(w);
    fifo_empty_out = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  int pops0;

  initial begin
    // Reset with a non-empty FIFO
    push(10'h000); push(10'h100); push(10'h200); push(10'h300);
    #4;
    check("rst_rd",    64'(fifo_read), 64'd0);
    check("rst_valid", 64'(valid_out), 64'd0);
    check("rst_data",  64'(data_out),  64'd0);
    check("rst_idle",  64'(idle),      64'd0);
    #10;
    check("rst_rd_b",    64'(fifo_read), 64'd0);
    check("rst_valid_b", 64'(valid_out), 64'd0);
    #1;
    reset = 1'b1;
    #1;
    check("idle_pre_edge", 64'(idle), 64'd0);
    step();
    check("idle_post_edge", 64'(idle), 64'd1);
    check("idle_no_pop",    64'(fifo_read), 64'd0);

    // Four words, one per lane, no pause
    enable = 1'b1;
    for (int i = 0; i < 6; i++) begin
      logic [3:0] ev;
      step();
      #1;
      ev = (i >= 2) ? (4'b0001 << (i - 2)) : 4'b0000;
      check($sformatf("t2_rd%0d", i), 64'(fifo_read), (i < 4) ? 64'd1 : 64'd0);
      check($sformatf("t2_v%0d", i),  64'(valid_out), 64'(ev));
      if (i >= 2) check($sformatf("t2_d%0d", i), 64'(data_out), 64'((i - 2) * 256));
    end

    // Lane-2 stream with pause[2] high for cycles 3..7
    step();
    obs.delete();
    for (int c = 0; c < 16; c++) begin
      logic [3:0] ev;
      if (c == 0) for (int k = 0; k < 8; k++) push(10'(32'h201 + k));
      if (c == 3) pause = 4'b0100;
      if (c == 8) pause = 4'b0000;
      #1;
      ev = (c == 2 || c == 3 || (c >= 9 && c <= 14)) ? 4'b0100 : 4'b0000;
      check($sformatf("t3_rd%0d", c), 64'(fifo_read),
            ((c <= 2) || (c >= 8 && c <= 12)) ? 64'd1 : 64'd0);
      check($sformatf("t3_v%0d", c), 64'(valid_out), 64'(ev));
      if (c == 2) check("t3_d2", 64'(data_out), 64'h201);
      if (c == 3) check("t3_d3", 64'(data_out), 64'h202);
      if (c >= 9 && c <= 14) check($sformatf("t3_d%0d", c), 64'(data_out), 64'(32'h203 + c - 9));
      step();
    end
    check("t3_count", 64'(obs.size()), 64'd8);
    for (int k = 0; k < 8 && k < obs.size(); k++)
      check($sformatf("t3_order%0d", k), 64'(obs[k]), 64'({4'b0100, 10'(32'h201 + k)}));
    check("no_pop_when_empty", 64'(rd_empty_err), 64'd0);

    // Drain with a held word on a paused lane
    for (int c = 0; c < 7; c++) begin
      if (c == 0) begin push(10'h3AA); push(10'h0CC); pause = 4'b1000; pops0 = pops; end
      if (c == 2) enable = 1'b0;
      if (c == 4) pause = 4'b0000;
      #1;
      check($sformatf("t5_rd%0d", c), 64'(fifo_read), (c == 0) ? 64'd1 : 64'd0);
      if (c == 5) begin
        check("t5_v",    64'(valid_out), 64'b1000);
        check("t5_d",    64'(data_out),  64'h3AA);
        check("t5_idle5", 64'(idle),     64'd0);
      end
      if (c == 6) begin
        check("t5_idle6", 64'(idle),      64'd1);
        check("t5_v6",    64'(valid_out), 64'd0);
      end
      step();
    end
    check("t5_pops", 64'(pops - pops0), 64'd1);
    check("t5_qleft", 64'(q.size()), 64'd1);

`ifdef DEMUX_COUNT_EN
    check("cnt_accum", 64'(words_out), 64'({8'd2, 8'd9, 8'd1, 8'd1}));
    reset = 1'b0;
    q.delete();
    fifo_empty_out = 1'b1;
    #1;
    check("cnt_rst0", 64'(words_out), 64'd0);
    step(); step();
    reset = 1'b1;
    step();
    for (int k = 0; k < 257; k++) push(10'h100 | 10'(k & 8'hFF));
    enable = 1'b1;
    repeat (270) step();
    check("cnt_lane0", 64'(words_out[0*CB +: CB]), 64'd0);
    check("cnt_lane1", 64'(words_out[1*CB +: CB]), 64'd1);
    check("cnt_lane2", 64'(words_out[2*CB +: CB]), 64'd0);
    check("cnt_lane3", 64'(words_out[3*CB +: CB]), 64'd0);
    for (int k = 0; k < 20; k++) push(10'h100 | 10'(k));
    repeat (6) step();
    check("cnt_mid", 64'(words_out[1*CB +: CB]), 64'd5);
    reset = 1'b0;
    #1;
    check("cnt_rst_mid", 64'(words_out), 64'd0);
    check("rst_mid_v",   64'(valid_out), 64'd0);
    check("rst_mid_rd",  64'(fifo_read), 64'd0);
    step();
    reset = 1'b1;
    step();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
